// File: rtl/gemm_tile_controller.sv
// Tiled signed GEMM: RowPar x ColPar outer-product MAC array plus M/N/K tile sequencer.
// Latency: 1 start cycle + ceil(M/RowPar)*ceil(N/ColPar)*(K+2) + 1 done cycle.
// Backpressure: none; SRAM reads are fixed 1-cycle and C writes always complete in one cycle.
module gemm_tile_controller #(
  parameter int RowPar        = 4,
  parameter int ColPar        = 16,
  parameter int InDataWidth   = 8,
  parameter int AccWidth      = 32,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [SizeAddrWidth-1:0]             M_size_i,
  input  logic [SizeAddrWidth-1:0]             K_size_i,
  input  logic [SizeAddrWidth-1:0]             N_size_i,
  output logic [AddrWidth-1:0]                 sram_a_addr_o,
  input  logic [RowPar*InDataWidth-1:0]        sram_a_rdata_i,
  output logic [AddrWidth-1:0]                 sram_b_addr_o,
  input  logic [ColPar*InDataWidth-1:0]        sram_b_rdata_i,
  output logic [AddrWidth-1:0]                 sram_c_addr_o,
  output logic [RowPar*ColPar*AccWidth-1:0]    sram_c_wdata_o,
  output logic                                 sram_c_we_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  // One extra bit so row/column base + array size never overflows in the edge compares.
  localparam int SW1 = SizeAddrWidth + 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [SizeAddrWidth-1:0] r_m, r_k, r_n, r_k_cnt;
  logic [SW1-1:0]           r_row_base, r_col_base;
  logic [AddrWidth-1:0]     r_a_base, r_b_base, r_c_addr;
  logic                     r_vld, r_first;
  logic                     w_last_k, w_last_row, w_last_col, w_zero;
  logic [RowPar-1:0]        w_row_ok;
  logic [ColPar-1:0]        w_col_ok;

  assign w_zero     = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  assign w_last_k   = (r_k_cnt == r_k - SizeAddrWidth'(1));
  assign w_last_row = (r_row_base + SW1'(RowPar)) >= {1'b0, r_m};
  assign w_last_col = (r_col_base + SW1'(ColPar)) >= {1'b0, r_n};

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: K read cycles, one drain, one write per tile.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nxt = w_zero ? S_DONE : S_READ;
      S_READ:  if (w_last_k) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (w_last_row && w_last_col) ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Size latch, k counter and tile walk (nt inner, mt outer); bases track mt*K, nt*K, mt*NT+nt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_m        <= '0;
      r_k        <= '0;
      r_n        <= '0;
      r_k_cnt    <= '0;
      r_row_base <= '0;
      r_col_base <= '0;
      r_a_base   <= '0;
      r_b_base   <= '0;
      r_c_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_m        <= M_size_i;
          r_k        <= K_size_i;
          r_n        <= N_size_i;
          r_k_cnt    <= '0;
          r_row_base <= '0;
          r_col_base <= '0;
          r_a_base   <= '0;
          r_b_base   <= '0;
          r_c_addr   <= '0;
        end
        S_READ: r_k_cnt <= w_last_k ? '0 : r_k_cnt + SizeAddrWidth'(1);
        S_WRITE: begin
          r_c_addr <= r_c_addr + AddrWidth'(1);
          if (w_last_col) begin
            r_col_base <= '0;
            r_b_base   <= '0;
            r_row_base <= r_row_base + SW1'(RowPar);
            r_a_base   <= r_a_base + AddrWidth'(r_k);
          end else begin
            r_col_base <= r_col_base + SW1'(ColPar);
            r_b_base   <= r_b_base + AddrWidth'(r_k);
          end
        end
        default: ;
      endcase
    end
  end

  // Read data lands one cycle after its address; flag the k=0 beat so the tile starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld   <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_vld   <= (r_state == S_READ);
      r_first <= (r_state == S_READ) && (r_k_cnt == '0);
    end
  end

  genvar gr, gc;
  generate
    for (gr = 0; gr < RowPar; gr++) begin : g_row_ok
      assign w_row_ok[gr] = (r_row_base + SW1'(gr)) < {1'b0, r_m};
    end
    for (gc = 0; gc < ColPar; gc++) begin : g_col_ok
      assign w_col_ok[gc] = (r_col_base + SW1'(gc)) < {1'b0, r_n};
    end
    for (gr = 0; gr < RowPar; gr++) begin : g_r
      for (gc = 0; gc < ColPar; gc++) begin : g_c
        localparam int Lane = gr * ColPar + gc;
        logic signed [2*InDataWidth-1:0] w_prod;
        logic signed [AccWidth-1:0]      w_prod_ext;
        logic signed [AccWidth-1:0]      r_acc;

        assign w_prod     = $signed(sram_a_rdata_i[gr*InDataWidth +: InDataWidth]) *
                            $signed(sram_b_rdata_i[gc*InDataWidth +: InDataWidth]);
        assign w_prod_ext = AccWidth'(w_prod);

        // Wrapping MAC: load on the first beat of a tile, accumulate afterwards.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i)      r_acc <= '0;
          else if (r_vld) r_acc <= r_first ? w_prod_ext : r_acc + w_prod_ext;
        end

        // Lanes past M or N on edge tiles are written as zero.
        assign sram_c_wdata_o[Lane*AccWidth +: AccWidth] =
          ((r_state == S_WRITE) && w_row_ok[gr] && w_col_ok[gc]) ? r_acc : '0;
      end
    end
  endgenerate

  assign sram_a_addr_o = (r_state == S_READ)  ? r_a_base + AddrWidth'(r_k_cnt) : '0;
  assign sram_b_addr_o = (r_state == S_READ)  ? r_b_base + AddrWidth'(r_k_cnt) : '0;
  assign sram_c_addr_o = (r_state == S_WRITE) ? r_c_addr : '0;
  assign sram_c_we_o   = (r_state == S_WRITE);
  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);

endmodule

// File: tb/tb_gemm_tile_controller.sv
module tb_gemm_tile_controller;
  localparam int RP = 4, CP = 16, IW = 8, AW = 12, SW = 32, NL = RP * CP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start32, start16;
  logic [SW-1:0]        m_sz, k_sz, n_sz;
  logic [AW-1:0]        a_addr32, b_addr32, c_addr32, a_addr16, b_addr16, c_addr16;
  logic [RP*IW-1:0]     a_rd32, a_rd16;
  logic [CP*IW-1:0]     b_rd32, b_rd16;
  logic [NL*32-1:0]     c_wd32;
  logic [NL*16-1:0]     c_wd16;
  logic                 we32, we16, busy32, busy16, done32, done16;

  gemm_tile_controller #(.RowPar(RP), .ColPar(CP), .InDataWidth(IW), .AccWidth(32),
                         .AddrWidth(AW), .SizeAddrWidth(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start32),
    .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz),
    .sram_a_addr_o(a_addr32), .sram_a_rdata_i(a_rd32),
    .sram_b_addr_o(b_addr32), .sram_b_rdata_i(b_rd32),
    .sram_c_addr_o(c_addr32), .sram_c_wdata_o(c_wd32), .sram_c_we_o(we32),
    .busy_o(busy32), .done_o(done32));

  gemm_tile_controller #(.RowPar(RP), .ColPar(CP), .InDataWidth(IW), .AccWidth(16),
                         .AddrWidth(AW), .SizeAddrWidth(SW)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16),
    .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz),
    .sram_a_addr_o(a_addr16), .sram_a_rdata_i(a_rd16),
    .sram_b_addr_o(b_addr16), .sram_b_rdata_i(b_rd16),
    .sram_c_addr_o(c_addr16), .sram_c_wdata_o(c_wd16), .sram_c_we_o(we16),
    .busy_o(busy16), .done_o(done16));

  // SRAM models with 1-cycle registered read
  logic [RP*IW-1:0] mem_a [0:4095];
  logic [CP*IW-1:0] mem_b [0:4095];
  always @(posedge clk) begin
    a_rd32 <= mem_a[a_addr32];
    b_rd32 <= mem_b[b_addr32];
    a_rd16 <= mem_a[a_addr16];
    b_rd16 <= mem_b[b_addr16];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          sel16;
  logic          w_we, w_busy, w_done;
  logic [AW-1:0] w_caddr;
  assign w_we    = sel16 ? we16    : we32;
  assign w_busy  = sel16 ? busy16  : busy32;
  assign w_done  = sel16 ? done16  : done32;
  assign w_caddr = sel16 ? c_addr16 : c_addr32;

  int checks = 0, passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    int m, k, n;
    int amode, aval, bmode, bval;
    bit w16;
    int nwr;   // expected number of C writes
    int l0;    // expected lane 0 of the last write
  } vec_t;

  vec_t tbl [6];

  // current operand pattern: mode 1 = index+1, mode 0 = constant
  int cm, ck, cn, amode, aval, bmode, bval;
  bit cw16;

  function automatic int a_of(int i, int k);
    return amode ? i + 1 : aval;
  endfunction

  function automatic int b_of(int k, int j);
    return bmode ? j + 1 : bval;
  endfunction

  // independent reference: plain matrix product, masked, wrapped to the accumulator width
  function automatic logic [31:0] exp_lane(int t, int l);
    int ntn, mt, nt, i, j, s;
    ntn = (cn + CP - 1) / CP;
    mt = t / ntn; nt = t % ntn;
    i = mt * RP + l / CP; j = nt * CP + l % CP;
    if (i >= cm || j >= cn) return 32'd0;
    s = 0;
    for (int kk = 0; kk < ck; kk++) s += a_of(i, kk) * b_of(kk, j);
    return cw16 ? (32'(s) & 32'h0000_FFFF) : 32'(s);
  endfunction

  // padding lanes get garbage so masking is actually exercised
  task automatic fill();
    int mtn, ntn;
    mtn = (cm + RP - 1) / RP;
    ntn = (cn + CP - 1) / CP;
    for (int mt = 0; mt < mtn; mt++)
      for (int kk = 0; kk < ck; kk++)
        for (int r = 0; r < RP; r++)
          mem_a[mt*ck+kk][r*IW +: IW] = (mt*RP + r < cm) ? 8'(a_of(mt*RP + r, kk)) : 8'd99;
    for (int nt = 0; nt < ntn; nt++)
      for (int kk = 0; kk < ck; kk++)
        for (int c = 0; c < CP; c++)
          mem_b[nt*ck+kk][c*IW +: IW] = (nt*CP + c < cn) ? 8'(b_of(kk, nt*CP + c)) : 8'd77;
  endtask

  task automatic load(input vec_t v);
    cm = v.m; ck = v.k; cn = v.n;
    amode = v.amode; aval = v.aval; bmode = v.bmode; bval = v.bval; cw16 = v.w16;
    fill();
    m_sz = 32'(v.m); k_sz = 32'(v.k); n_sz = 32'(v.n);
    sel16 = v.w16;
  endtask

  logic [31:0]   cap [0:15][0:NL-1];
  logic [AW-1:0] cap_addr [0:15];
  int            cap_cyc [0:15];
  int            cap_n;

  task automatic run_vec(input vec_t v, input bit hold, input string nm);
    int s, exp_lat, mtn, ntn, done_cnt, done_cyc, busy_cnt, post, bad;
    bit seen;
    load(v);
    mtn = (v.m + RP - 1) / RP;
    ntn = (v.n + CP - 1) / CP;
    exp_lat = (v.m == 0 || v.k == 0 || v.n == 0) ? 1 : 1 + mtn * ntn * (v.k + 2);
    cap_n = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0; post = 0; seen = 0;
    @(negedge clk);
    if (v.w16) start16 = 1'b1; else start32 = 1'b1;
    s = cyc;
    for (int it = 0; it < 3000 && post < 4; it++) begin
      @(negedge clk);
      if (w_busy) busy_cnt++;
      if (w_we) begin
        if (cap_n < 16) begin
          for (int l = 0; l < NL; l++)
            cap[cap_n][l] = sel16 ? {16'h0, c_wd16[l*16 +: 16]} : c_wd32[l*32 +: 32];
          cap_addr[cap_n] = w_caddr;
          cap_cyc[cap_n]  = cyc;
        end
        cap_n++;
      end
      if (w_done) begin done_cnt++; done_cyc = cyc; seen = 1'b1; end
      else if (seen) post++;
      if (!hold || post >= 1) begin start32 = 1'b0; start16 = 1'b0; end
    end
    start32 = 1'b0; start16 = 1'b0;
    if (!seen) chk({nm, " timeout waiting for done"}, 32'd0, 32'd1);
    chk({nm, " done pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, " start-to-done cycles"}, 32'(done_cyc - s), 32'(exp_lat));
    chk({nm, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    chk({nm, " write count"}, 32'(cap_n), 32'(v.nwr));
    for (int t = 0; t < cap_n && t < 16; t++) begin
      chk($sformatf("%s w%0d addr", nm, t), 32'(cap_addr[t]), 32'(t));
      chk($sformatf("%s w%0d cycle", nm, t), 32'(cap_cyc[t] - s), 32'((t + 1) * (v.k + 2)));
      bad = 0;
      for (int l = 0; l < NL; l++) if (cap[t][l] !== exp_lane(t, l)) bad++;
      chk($sformatf("%s w%0d bad lanes", nm, t), 32'(bad), 32'd0);
    end
    if (cap_n > 0 && cap_n <= 16)
      chk({nm, " lane0 last tile"}, cap[cap_n-1][0],
          v.w16 ? (32'(v.l0) & 32'h0000_FFFF) : 32'(v.l0));
  endtask

  initial begin
    int s, nw, nb;
    rst = 1'b1; start32 = 1'b0; start16 = 1'b0; sel16 = 1'b0;
    m_sz = '0; k_sz = '0; n_sz = '0;
    #1;
    chk("reset busy", 32'(busy32), 32'd0);
    chk("reset we", 32'(we32), 32'd0);
    chk("reset done", 32'(done32), 32'd0);
    chk("reset a addr", 32'(a_addr32), 32'd0);
    chk("reset wdata nonzero", 32'(|c_wd32), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    //          m   k   n  am  av    bm  bv    w16 nwr l0
    tbl[0] = '{4, 64, 16, 0,  1,    0,  2,    1'b0, 1, 128};
    tbl[1] = '{6,  3, 20, 1,  0,    1,  0,    1'b0, 4, 255};
    tbl[2] = '{4, 64, 16, 0, -128,  0, -128,  1'b1, 1, 0};
    tbl[3] = '{4,  1, 16, 0, -128,  0, -128,  1'b1, 1, 16384};
    tbl[4] = '{4,  4,  0, 0,  1,    0,  1,    1'b0, 0, 0};
    tbl[5] = '{1,  1,  1, 0,  7,    0, -3,    1'b0, 1, -21};

    for (int v = 0; v < 6; v++) run_vec(tbl[v], 1'b0, $sformatf("vec%0d", v));

    // start held high for the whole run, including the DONE cycle
    run_vec(tbl[1], 1'b1, "hold");
    chk("hold tile3 lane(0,4) masked", cap[3][4], 32'd0);
    chk("hold tile3 lane(2,0) masked", cap[3][32], 32'd0);
    chk("hold tile3 lane(1,3)", cap[3][19], 32'd360);

    // reset in the middle of tile 1 READ
    load(tbl[1]);
    nw = 0;
    @(negedge clk); start32 = 1'b1; s = cyc;
    @(negedge clk); start32 = 1'b0;
    if (we32) nw++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (we32) nw++;
    end
    chk("pre-reset cycle offset", 32'(cyc - s), 32'd7);
    chk("pre-reset b addr", 32'(b_addr32), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("abort a addr", 32'(a_addr32), 32'd0);
    chk("abort b addr", 32'(b_addr32), 32'd0);
    chk("abort c addr", 32'(c_addr32), 32'd0);
    chk("abort we", 32'(we32), 32'd0);
    chk("abort busy", 32'(busy32), 32'd0);
    chk("abort done", 32'(done32), 32'd0);
    chk("abort wdata nonzero", 32'(|c_wd32), 32'd0);
    chk("writes before abort", 32'(nw), 32'd1);
    @(negedge clk); rst = 1'b0;
    nw = 0; nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (we32) nw++;
      if (busy32) nb++;
    end
    chk("writes after abort", 32'(nw), 32'd0);
    chk("busy after abort", 32'(nb), 32'd0);

    run_vec(tbl[1], 1'b0, "rerun");
    chk("rerun tile3 lane(0,0)", cap[3][0], 32'd255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
